// File: rtl/int_ctrl_if.sv
// int_ctrl_if: single-cycle register bus between a CPU-side master and int_ctrl.
// Ports: STB/WE/ADDR/DAT_I from master, DAT_O/ACK from slave.
interface int_ctrl_if;
  logic        STB;
  logic        WE;
  logic [31:0] ADDR;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic        ACK;

  modport master (
    output STB, WE, ADDR, DAT_I,
    input  DAT_O, ACK
  );

  modport slave (
    input  STB, WE, ADDR, DAT_I,
    output DAT_O, ACK
  );
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: edge/level interrupt controller, fixed priority (source 0 first).
// Ports: clk, rstn (async low), src[N_SRC], bus (int_ctrl_if.slave), INT, CAUSE.
// Map ADDR[3:2]: 0 PENDING (W1C), 1 MASK, 2 CAUSE (RO), 3 MODE (1 = level).
// Build macro INT_CTRL_SYNC_EN adds a two-flop synchronizer on every src bit.
module int_ctrl #(
  parameter int               N_SRC    = 6,
  parameter logic [N_SRC-1:0] MASK_RST = '1,
  parameter logic [N_SRC-1:0] MODE_RST = '0
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_SRC-1:0] src,
  int_ctrl_if.slave        bus,
  output logic             INT,
  output logic [31:0]      CAUSE
);

  logic [N_SRC-1:0] s;
  logic [N_SRC-1:0] s_d;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] mask_q;
  logic [N_SRC-1:0] mode_q;
  logic [N_SRC-1:0] pend_n;
  logic [N_SRC-1:0] g;
  logic [N_SRC-1:0] wdat;
  logic [N_SRC-1:0] edge_set;
  logic [N_SRC-1:0] edge_nx;
  logic [N_SRC-1:0] lvl_nx;
  logic [4:0]       cause_q;
  logic [4:0]       cause_n;
  logic [31:0]      rdat;
  logic             ack_q;
  logic             int_q;
  logic             wr;
  logic             wr_pend;
  logic             wr_mask;
  logic             wr_mode;
  logic             armed;
  logic             unused_bits;

`ifdef INT_CTRL_SYNC_EN
  localparam int ARM_W = 3;

  logic [N_SRC-1:0] sync1_q;
  logic [N_SRC-1:0] sync2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  localparam int ARM_W = 1;

  assign s = src;
`endif

  // Edge detection stays off until s_d holds a real post-reset sample,
  // so a line already high at release never looks like a rising edge.
  logic [ARM_W-1:0] arm_q;
  assign armed = arm_q[ARM_W-1];

  assign unused_bits = ^{bus.ADDR[31:4], bus.ADDR[1:0], bus.DAT_I};

  assign wdat    = bus.DAT_I[N_SRC-1:0];
  assign wr      = bus.STB & bus.WE & ~ack_q;
  assign wr_pend = wr & (bus.ADDR[3:2] == 2'd0);
  assign wr_mask = wr & (bus.ADDR[3:2] == 2'd1);
  assign wr_mode = wr & (bus.ADDR[3:2] == 2'd3);

  // Edge: a new edge beats a coincident clear.
  // Level: follows s, except a 1->0 MODE write drops the bit.
  assign edge_set = {N_SRC{armed}} & s & ~s_d;
  assign edge_nx  = edge_set
                  | (pend_q & ~({N_SRC{wr_pend}} & wdat));
  assign lvl_nx   = s & ~({N_SRC{wr_mode}} & ~wdat);
  assign pend_n   = (mode_q & lvl_nx) | (~mode_q & edge_nx);

  assign g = pend_q & mask_q;

  always_comb begin
    cause_n = cause_q;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (g[i]) cause_n = 5'(i);
    end
  end

  always_comb begin
    rdat = '0;
    unique case (bus.ADDR[3:2])
      2'd0: rdat[N_SRC-1:0] = pend_q;
      2'd1: rdat[N_SRC-1:0] = mask_q;
      2'd2: rdat[4:0]       = cause_q;
      2'd3: rdat[N_SRC-1:0] = mode_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ack_q   <= 1'b0;
      arm_q   <= '0;
      s_d     <= '0;
      pend_q  <= '0;
      mask_q  <= MASK_RST;
      mode_q  <= MODE_RST;
      int_q   <= 1'b0;
      cause_q <= '0;
    end else begin
      ack_q   <= bus.STB;
      arm_q   <= (arm_q << 1) | ARM_W'(1);
      s_d     <= s;
      pend_q  <= pend_n;
      int_q   <= |g;
      cause_q <= cause_n;
      if (wr_mask) mask_q <= wdat;
      if (wr_mode) mode_q <= wdat;
    end
  end

  assign bus.DAT_O = rdat;
  assign bus.ACK   = ack_q;
  assign INT       = int_q;
  assign CAUSE     = {27'd0, cause_q};

endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: register vectors plus sequences for edge, level, mask,
// held-strobe and reset corners of int_ctrl (N_SRC = 6).
module tb_int_ctrl;

`ifdef INT_CTRL_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rstn;
  logic [5:0]  src;
  logic        irq;
  logic [31:0] cause;

  int checks = 0;
  int errors = 0;

  int_ctrl_if bus ();

  int_ctrl dut (
    .clk   (clk),
    .rstn  (rstn),
    .src   (src),
    .bus   (bus.slave),
    .INT   (irq),
    .CAUSE (cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } sb_t;

  vec_t vt[13];
  sb_t  sb[$];

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for ACK", name);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.ACK && n < 4) begin
      @(negedge clk);
      n++;
    end
    if (bus.ACK) timeout("ack_release");
  endtask

  task automatic wait_ack(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.ACK && n < 4);
    if (!bus.ACK) timeout(name);
  endtask

  task automatic bus_write(input logic [31:0] a,
                           input logic [31:0] d);
    wait_idle();
    bus.STB   = 1'b1;
    bus.WE    = 1'b1;
    bus.ADDR  = a;
    bus.DAT_I = d;
    wait_ack("write_ack");
    bus.STB = 1'b0;
    bus.WE  = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a,
                          input logic [31:0] exp,
                          input string name);
    sb_t e;
    wait_idle();
    bus.STB  = 1'b1;
    bus.WE   = 1'b0;
    bus.ADDR = a;
    sb.push_back('{name, exp});
    wait_ack(name);
    e = sb.pop_front();
    check(e.name, bus.DAT_O, e.exp);
    bus.STB = 1'b0;
  endtask

  initial begin
    vt[0]  = '{1'b0, 32'h00, 32'h0,        32'h00};
    vt[1]  = '{1'b0, 32'h04, 32'h0,        32'h3F};
    vt[2]  = '{1'b0, 32'h08, 32'h0,        32'h00};
    vt[3]  = '{1'b0, 32'h0C, 32'h0,        32'h00};
    vt[4]  = '{1'b1, 32'h04, 32'hFFFFFFC5, 32'h00};
    vt[5]  = '{1'b0, 32'h04, 32'h0,        32'h05};
    vt[6]  = '{1'b1, 32'h08, 32'h0000001F, 32'h00};
    vt[7]  = '{1'b0, 32'h08, 32'h0,        32'h00};
    vt[8]  = '{1'b1, 32'h0C, 32'hFFFFFFC0, 32'h00};
    vt[9]  = '{1'b0, 32'h0C, 32'h0,        32'h00};
    vt[10] = '{1'b1, 32'h04, 32'h0000003F, 32'h00};
    vt[11] = '{1'b0, 32'h14, 32'h0,        32'h3F};
    vt[12] = '{1'b0, 32'h10, 32'h0,        32'h00};

    rstn      = 1'b0;
    src       = 6'h04;
    bus.STB   = 1'b0;
    bus.WE    = 1'b0;
    bus.ADDR  = '0;
    bus.DAT_I = '0;

    // reset state, with src[2] already high
    repeat (3) @(negedge clk);
    check("rst_int",   {31'd0, irq},     32'd0);
    check("rst_cause", cause,            32'd0);
    check("rst_ack",   {31'd0, bus.ACK}, 32'd0);
    rstn = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    check("hi_at_release_int", {31'd0, irq}, 32'd0);
    bus_read(32'h0, 32'h0, "hi_at_release_pend");
    src = 6'h00;
    repeat (LAT + 2) @(negedge clk);

    // register map vectors
    for (int i = 0; i < 13; i++) begin
      if (vt[i].we) bus_write(vt[i].addr, vt[i].data);
      else bus_read(vt[i].addr, vt[i].exp, $sformatf("vec%0d", i));
    end
    repeat (2) @(negedge clk);

    // single edge latency
    src[3] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    check("lat_early_int", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("lat_int",   {31'd0, irq}, 32'd1);
    check("lat_cause", cause,        32'd3);
    bus_read(32'h0, 32'h08, "lat_pend");
    bus_write(32'h0, 32'h08);
    @(negedge clk);
    check("clr3_int",   {31'd0, irq}, 32'd0);
    check("clr3_cause", cause,        32'd3);
    repeat (3) @(negedge clk);
    check("no_retrig_int", {31'd0, irq}, 32'd0);
    src[3] = 1'b0;
    repeat (LAT) @(negedge clk);

    // simultaneous sources and priority
    src[1] = 1'b1;
    src[4] = 1'b1;
    repeat (LAT) @(negedge clk);
    check("pri_int",   {31'd0, irq}, 32'd1);
    check("pri_cause", cause,        32'd1);
    bus_write(32'h0, 32'h02);
    @(negedge clk);
    check("pri2_int",   {31'd0, irq}, 32'd1);
    check("pri2_cause", cause,        32'd4);
    bus_write(32'h0, 32'h10);
    @(negedge clk);
    check("pri3_int",   {31'd0, irq}, 32'd0);
    check("pri3_cause", cause,        32'd4);
    src = 6'h00;
    repeat (LAT) @(negedge clk);

    // masked pending bit
    bus_write(32'h4, 32'h00);
    src[2] = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    check("mask_int", {31'd0, irq}, 32'd0);
    bus_read(32'h0, 32'h04, "mask_pend");
    bus_write(32'h4, 32'h04);
    check("unmask_int0", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("unmask_int1", {31'd0, irq}, 32'd1);
    check("unmask_cause", cause,       32'd2);
    bus_write(32'h0, 32'h04);
    bus_write(32'h4, 32'h3F);
    src[2] = 1'b0;
    repeat (LAT + 1) @(negedge clk);
    check("mask_done_int", {31'd0, irq}, 32'd0);

    // level mode on source 5
    bus_write(32'hC, 32'h20);
    @(negedge clk);
    src[5] = 1'b1;
    repeat (LAT) @(negedge clk);
    check("lvl_int",   {31'd0, irq}, 32'd1);
    check("lvl_cause", cause,        32'd5);
    bus_write(32'h0, 32'h20);
    @(negedge clk);
    check("lvl_w1c_int", {31'd0, irq}, 32'd1);
    bus_read(32'h0, 32'h20, "lvl_w1c_pend");
    repeat (2) @(negedge clk);
    check("lvl_hold_int", {31'd0, irq}, 32'd1);
    src[5] = 1'b0;
    repeat (LAT) @(negedge clk);
    check("lvl_low_int", {31'd0, irq}, 32'd0);

    // level to edge while line is high
    src[5] = 1'b1;
    repeat (LAT) @(negedge clk);
    check("l2e_int0", {31'd0, irq}, 32'd1);
    bus_write(32'hC, 32'h00);
    repeat (LAT + 2) @(negedge clk);
    check("l2e_int", {31'd0, irq}, 32'd0);
    bus_read(32'h0, 32'h00, "l2e_pend");
    src[5] = 1'b0;
    repeat (LAT + 1) @(negedge clk);

    // edge coincident with a clear of the same bit
    src[0] = 1'b1;
    repeat (LAT - 2) @(negedge clk);
    bus_write(32'h0, 32'h01);
    bus_read(32'h0, 32'h01, "coinc_pend");
    src[0] = 1'b0;
    repeat (LAT + 1) @(negedge clk);

    // held strobe: one clear, later edges survive
    wait_idle();
    bus.STB   = 1'b1;
    bus.WE    = 1'b1;
    bus.ADDR  = 32'h0;
    bus.DAT_I = 32'h01;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k == 1) check("held_clr", bus.DAT_O, 32'h00);
      if (k < 5) src[0] = k[0];
    end
    check("held_ack",  {31'd0, bus.ACK}, 32'd1);
    check("held_pend", bus.DAT_O,        32'h01);
    bus.STB = 1'b0;
    bus.WE  = 1'b0;
    src[0]  = 1'b0;
    @(negedge clk);
    check("held_done_int", {31'd0, irq}, 32'd1);
    bus_write(32'h0, 32'h01);
    repeat (2) @(negedge clk);

    // reset during an acknowledged MASK write
    bus.STB   = 1'b1;
    bus.WE    = 1'b1;
    bus.ADDR  = 32'h4;
    bus.DAT_I = 32'h00;
    @(negedge clk);
    check("rst_mid_ack1", {31'd0, bus.ACK}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("rst_mid_ack0", {31'd0, bus.ACK}, 32'd0);
    bus.STB = 1'b0;
    bus.WE  = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    bus_read(32'h4, 32'h3F, "rst_mask");
    check("rst2_int", {31'd0, irq}, 32'd0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
